// File: rtl/pc_fetch_controller_if.sv
// Bus bundle between the fetch controller and its neighbours: the
// program_counter (pc_count in; increment/jump_set/jumpcount out), the
// instruction memory (req/addr/ack/rdata), the execute stage
// (instr/instr_valid in, exec_done/branch_* back), plus start/halt control
// and the halted/fault/retired status.
//   master : the fetch controller side
//   slave  : the environment side (PC, memory, execute unit, control)
interface pc_fetch_controller_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               start;
    logic               halt_req;
    logic [ADDR_W-1:0]  pc_count;
    logic               pc_increment;
    logic               pc_jump_set;
    logic [ADDR_W-1:0]  pc_jumpcount;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               exec_done;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               halted;
    logic               fault;
    logic [15:0]        retired;

    modport master (
        input  start, halt_req, pc_count, mem_ack, mem_rdata,
               exec_done, branch_taken, branch_target,
        output pc_increment, pc_jump_set, pc_jumpcount, mem_req, mem_addr,
               instr, instr_valid, halted, fault, retired
    );

    modport slave (
        output start, halt_req, pc_count, mem_ack, mem_rdata,
               exec_done, branch_taken, branch_target,
        input  pc_increment, pc_jump_set, pc_jumpcount, mem_req, mem_addr,
               instr, instr_valid, halted, fault, retired
    );
endinterface

// File: rtl/pc_fetch_controller.sv
// Instruction-fetch sequencer. Requests the instruction at the current PC,
// captures it, hands it to the execute stage, then increments or redirects
// the PC based on branch resolution. Reports halt, memory-timeout fault and
// a retired-instruction count.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pc_fetch_controller_if.master (PC control, memory read,
//           execute handshake, start/halt control, status)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, waits for start
// S_REQ    | mem_req high at pc_count, waits for mem_ack (timeout -> FAULT)
// S_ISSUE  | instr_valid pulse; HALT opcode skips execution
// S_EXEC   | waits for exec_done, latches branch decision
// S_UPDATE | one-cycle PC increment or jump, retired count advances
// S_HALT   | halted, start resumes fetching
// S_FAULT  | memory timeout, only reset leaves
module pc_fetch_controller #(
    parameter int         ADDR_W      = 16,
    parameter int         INSTR_W     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         TIMEOUT     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    pc_fetch_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_EXEC,
        S_UPDATE,
        S_HALT,
        S_FAULT
    } state_t;

    // Counter only needs to hold 0 .. TIMEOUT-1.
    localparam int             TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    state_t             state, state_nx;
    logic [TW-1:0]      to_cnt;
    logic               halt_pending;
    logic               halt_set;
    logic               halt_op;
    logic [INSTR_W-1:0] instr_q;
    logic [15:0]        retired_q;

    logic               inc_q, inc_nx;
    logic               jump_q, jump_nx;
    logic [ADDR_W-1:0]  jc_q, jc_nx;
    logic               iv_q, iv_nx;

    assign halt_op  = (instr_q[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign halt_set = bus.halt_req &&
                      (state inside {S_REQ, S_ISSUE, S_EXEC, S_UPDATE});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The PC-control and instr_valid outputs are registered: their next
    // values are decoded alongside the transition into UPDATE/ISSUE so
    // they are high exactly while the FSM sits in that state.
    always_comb begin
        state_nx = state;
        inc_nx   = 1'b0;
        jump_nx  = 1'b0;
        jc_nx    = '0;
        iv_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    state_nx = S_ISSUE;
                    iv_nx    = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = S_FAULT;
                end
            end
            S_ISSUE: begin
                if (halt_op) begin
                    state_nx = S_UPDATE;
                    inc_nx   = 1'b1;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    state_nx = S_UPDATE;
                    if (bus.branch_taken) begin
                        jump_nx = 1'b1;
                        jc_nx   = bus.branch_target;
                    end else begin
                        inc_nx  = 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                // A halt request arriving in UPDATE itself still stops
                // fetching after this instruction.
                state_nx = (halt_pending || bus.halt_req) ? S_HALT : S_REQ;
            end
            S_HALT: begin
                if (bus.start) state_nx = S_REQ;
            end
            S_FAULT: begin
                state_nx = S_FAULT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inc_q  <= 1'b0;
            jump_q <= 1'b0;
            jc_q   <= '0;
            iv_q   <= 1'b0;
        end else begin
            inc_q  <= inc_nx;
            jump_q <= jump_nx;
            jc_q   <= jc_nx;
            iv_q   <= iv_nx;
        end
    end

    // Consecutive unacknowledged REQ cycles; cleared outside REQ and on ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == S_REQ && !bus.mem_ack) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_pending <= 1'b0;
        end else if (state == S_HALT && bus.start) begin
            halt_pending <= 1'b0;
        end else if (halt_set || (state == S_ISSUE && halt_op)) begin
            halt_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
        end else if (state == S_REQ && bus.mem_ack) begin
            instr_q <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (state == S_UPDATE) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    // Decoded straight from the state register so the async reset drops
    // mem_req without waiting for a clock edge.
    assign bus.mem_req      = (state == S_REQ);
    assign bus.mem_addr     = (state == S_REQ) ? bus.pc_count : '0;
    assign bus.halted       = (state == S_HALT);
    assign bus.fault        = (state == S_FAULT);
    assign bus.instr        = instr_q;
    assign bus.instr_valid  = iv_q;
    assign bus.pc_increment = inc_q;
    assign bus.pc_jump_set  = jump_q;
    assign bus.pc_jumpcount = jc_q;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: a behavioural program_counter, a memory and
// execute-stage responder driven per instruction, a table of directed
// instructions, randomized instructions checked against a PC/retire model,
// plus timeout-fault and asynchronous-reset sequences.
module tb_pc_fetch_controller;

    logic clock;
    logic reset;

    pc_fetch_controller_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    pc_fetch_controller #(
        .ADDR_W(16), .INSTR_W(16), .HALT_OPCODE(4'hF), .TIMEOUT(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // program_counter stand-in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                bus.pc_count <= 16'h0000;
        else if (bus.pc_jump_set)  bus.pc_count <= bus.pc_jumpcount;
        else if (bus.pc_increment) bus.pc_count <= bus.pc_count + 16'd1;
    end

    typedef struct {
        logic [15:0] data;
        int          ack_dly;
        int          exec_dly;
        logic        taken;
        logic [15:0] target;
        logic        hreq;
        logic [15:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_pc;
    logic [15:0] model_ret;
    vec_t        tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Entered at a negedge with the controller in REQ; leaves the same way
    // (resuming with start if the instruction ends in HALT).
    task automatic do_instr(input vec_t v);
        logic is_halt;
        logic tk;
        is_halt = (v.data[15:12] == 4'hF);
        tk      = v.taken && !is_halt;
        for (int i = 0; i < v.ack_dly; i++) begin
            check("req_wait", bus.mem_req, 1);
            check("addr_wait", bus.mem_addr, model_pc);
            tick();
        end
        check("req", bus.mem_req, 1);
        check("addr", bus.mem_addr, model_pc);
        check("no_fault", bus.fault, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.data;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        check("instr_valid", bus.instr_valid, 1);
        check("instr", bus.instr, v.data);
        check("issue_no_req", bus.mem_req, 0);
        if (v.hreq && (is_halt || v.exec_dly == 0)) bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        if (!is_halt) begin
            for (int i = 0; i < v.exec_dly; i++) begin
                check("iv_one_cycle", bus.instr_valid, 0);
                check("exec_no_pc", {bus.pc_increment, bus.pc_jump_set}, 0);
                if (v.hreq && i == 0) bus.halt_req = 1'b1;
                bus.branch_taken  = 1'($urandom);
                bus.branch_target = 16'($urandom);
                tick();
                bus.halt_req = 1'b0;
            end
            bus.exec_done     = 1'b1;
            bus.branch_taken  = v.taken;
            bus.branch_target = v.target;
            tick();
            bus.exec_done     = 1'b0;
            bus.branch_taken  = 1'b0;
            bus.branch_target = 16'h0000;
        end
        check("upd_inc", bus.pc_increment, !tk);
        check("upd_jump", bus.pc_jump_set, tk);
        check("upd_jcount", bus.pc_jumpcount, tk ? v.target : 16'h0000);
        check("upd_iv_low", bus.instr_valid, 0);
        tick();
        model_ret = model_ret + 16'd1;
        model_pc  = v.exp_pc;
        check("after_inc_low", bus.pc_increment | bus.pc_jump_set, 0);
        check("retired", bus.retired, model_ret);
        check("halted", bus.halted, v.exp_halt);
        check("req_after", bus.mem_req, !v.exp_halt);
        if (!v.exp_halt) begin
            check("next_addr", bus.mem_addr, v.exp_pc);
        end else begin
            check("halt_pc", bus.pc_count, v.exp_pc);
            tick();
            check("halt_hold", bus.mem_req, 0);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check("resume_addr", bus.mem_addr, v.exp_pc);
            check("resume_halted", bus.halted, 0);
        end
    endtask

    initial begin
        vec_t rv;
        bus.start = 0; bus.halt_req = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        bus.exec_done = 0; bus.branch_taken = 0; bus.branch_target = 0;
        reset = 1'b0;

        //        data     ack exe tk  target   hreq exp_pc  exp_halt
        tbl[0] = '{16'h1234, 0, 0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tbl[1] = '{16'h2222, 2, 1, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0};
        tbl[2] = '{16'h3333, 0, 0, 1'b0, 16'h1111, 1'b0, 16'hFFFF, 1'b0};
        tbl[3] = '{16'h4444, 1, 2, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{16'h5555, 0, 0, 1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0};
        tbl[5] = '{16'hF000, 0, 0, 1'b1, 16'h0ABC, 1'b0, 16'h0006, 1'b1};
        tbl[6] = '{16'h7777, 0, 3, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1};
        tbl[7] = '{16'h8888, 7, 0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0};

        repeat (2) @(negedge clock);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_iv", bus.instr_valid, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_pcctl", {bus.pc_increment, bus.pc_jump_set, bus.pc_jumpcount}, 0);
        check("rst_status", {bus.halted, bus.fault}, 0);
        reset = 1'b1;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check("idle_ignores_halt", bus.halted | bus.mem_req, 0);
        model_pc  = 16'h0000;
        model_ret = 16'h0000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        for (int i = 0; i < 8; i++) do_instr(tbl[i]);

        for (int n = 0; n < 40; n++) begin
            rv.data     = 16'($urandom);
            rv.ack_dly  = int'($urandom_range(0, 7));
            rv.exec_dly = int'($urandom_range(0, 4));
            rv.taken    = 1'($urandom);
            rv.target   = 16'($urandom);
            rv.hreq     = ($urandom_range(0, 9) == 0);
            rv.exp_halt = (rv.data[15:12] == 4'hF) || rv.hreq;
            rv.exp_pc   = (rv.taken && rv.data[15:12] != 4'hF) ? rv.target
                                                               : model_pc + 16'd1;
            do_instr(rv);
        end

        // memory never answers: exactly TIMEOUT REQ cycles, then FAULT
        for (int i = 0; i < 8; i++) begin
            check("to_req", bus.mem_req, 1);
            check("to_no_fault", bus.fault, 0);
            tick();
        end
        check("fault_set", bus.fault, 1);
        check("fault_req_low", bus.mem_req, 0);
        bus.start = 1'b1;
        bus.halt_req = 1'b1;
        repeat (2) tick();
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        check("fault_sticky", bus.fault, 1);
        check("fault_no_req", bus.mem_req | bus.halted, 0);
        reset = 1'b0;
        #1;
        check("fault_cleared", bus.fault, 0);
        @(negedge clock);
        reset = 1'b1;
        model_pc  = 16'h0000;
        model_ret = 16'h0000;
        tick();
        check("idle_after_rst", bus.mem_req, 0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rv = '{16'h0ABC, 0, 1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
        do_instr(rv);
        check("pre_rst_req", bus.mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_mem_req", bus.mem_req, 0);
        check("async_instr", bus.instr, 0);
        check("async_retired", bus.retired, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("async_idle", bus.mem_req | bus.halted | bus.fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
